// File: rtl/types_pkg.sv
// Shared types for the node port controller: data word, port directions,
// physical port indices, LAST-direction encoding and controller FSM states.
package types_pkg;

  localparam int unsigned WORD_W  = 11;
  localparam int unsigned N_PORTS = 4;

  typedef logic signed [WORD_W-1:0] word_t;

  // Direction operand as decoded from the instruction
  typedef enum logic [2:0] {
    UP    = 3'd0,
    DOWN  = 3'd1,
    LEFT  = 3'd2,
    RIGHT = 3'd3,
    ANY   = 3'd4,
    LAST  = 3'd5,
    NIL   = 3'd6
  } port_t;

  // Physical port indices; lower index has higher ANY priority
  localparam logic [1:0] IDX_LEFT  = 2'd0;
  localparam logic [1:0] IDX_RIGHT = 2'd1;
  localparam logic [1:0] IDX_UP    = 2'd2;
  localparam logic [1:0] IDX_DOWN  = 2'd3;

  // Port remembered by the last ANY read; LD_NONE until one completes
  typedef enum logic [2:0] {
    LD_LEFT  = 3'd0,
    LD_RIGHT = 3'd1,
    LD_UP    = 3'd2,
    LD_DOWN  = 3'd3,
    LD_NONE  = 3'd4
  } last_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Physical ports addressed by a direction operand; empty for NIL and
  // for LAST before any ANY read has completed.
  function automatic logic [N_PORTS-1:0] dir_mask(input port_t dir, input last_t last);
    logic [N_PORTS-1:0] m;
    m = '0;
    case (dir)
      LEFT:  m[IDX_LEFT]  = 1'b1;
      RIGHT: m[IDX_RIGHT] = 1'b1;
      UP:    m[IDX_UP]    = 1'b1;
      DOWN:  m[IDX_DOWN]  = 1'b1;
      ANY:   m = '1;
      LAST: begin
        case (last)
          LD_LEFT:  m[IDX_LEFT]  = 1'b1;
          LD_RIGHT: m[IDX_RIGHT] = 1'b1;
          LD_UP:    m[IDX_UP]    = 1'b1;
          LD_DOWN:  m[IDX_DOWN]  = 1'b1;
          default:  m = '0;
        endcase
      end
      default: m = '0;
    endcase
    return m;
  endfunction

  // Encode a one-hot port grant as a LAST direction
  function automatic last_t grant_to_last(input logic [N_PORTS-1:0] g);
    last_t l;
    if (g[IDX_LEFT])       l = LD_LEFT;
    else if (g[IDX_RIGHT]) l = LD_RIGHT;
    else if (g[IDX_UP])    l = LD_UP;
    else if (g[IDX_DOWN])  l = LD_DOWN;
    else                   l = LD_NONE;
    return l;
  endfunction

endpackage

// File: rtl/port_arb.sv
// Fixed-priority 4-way one-hot selector (LEFT > RIGHT > UP > DOWN).
module port_arb
  import types_pkg::*;
(
  input  logic [N_PORTS-1:0] req,
  output logic [N_PORTS-1:0] grant
);

  // Highest-priority requester wins; no request gives an empty grant
  always_comb begin
    grant = '0;
    if (req[IDX_LEFT])       grant[IDX_LEFT]  = 1'b1;
    else if (req[IDX_RIGHT]) grant[IDX_RIGHT] = 1'b1;
    else if (req[IDX_UP])    grant[IDX_UP]    = 1'b1;
    else if (req[IDX_DOWN])  grant[IDX_DOWN]  = 1'b1;
  end

endmodule

// File: rtl/port_ctrl.sv
// Node port controller: performs port reads/writes for the decoded
// instruction, stalling the pc until the neighbour handshake completes.
module port_ctrl
  import types_pkg::*;
(
  input  logic               CLK,
  input  logic               nRST,
  input  logic               halt,
  input  logic               rd_req,
  input  logic               wr_req,
  input  port_t              rd_dir,
  input  port_t              wr_dir,
  input  word_t              wr_data,
  output word_t              rd_data,
  output logic               rd_done,
  output logic               wr_done,
  output logic               stall,
  input  word_t              in_data  [N_PORTS],
  input  logic [N_PORTS-1:0] in_valid,
  output logic [N_PORTS-1:0] in_ready,
  output word_t              out_data [N_PORTS],
  output logic [N_PORTS-1:0] out_valid,
  input  logic [N_PORTS-1:0] out_ready
);

  state_t             state, state_nxt;
  last_t              last_dir;
  word_t              wr_val;
  word_t              rd_val;
  logic               rd_op, wr_op;
  logic               rd_step, wr_step;
  logic [N_PORTS-1:0] rd_mask, wr_mask;
  logic [N_PORTS-1:0] arb_req, arb_grant;

  // One arbiter serves both directions: RD_WAIT and WR_WAIT never overlap,
  // so its request input is muxed by state.
  port_arb u_arb (
    .req   (arb_req),
    .grant (arb_grant)
  );

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, stall and handshake outputs
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    in_ready  = '0;
    out_valid = '0;
    arb_req   = '0;
    rd_step   = 1'b0;
    wr_step   = 1'b0;
    rd_mask   = dir_mask(rd_dir, last_dir);
    wr_mask   = dir_mask(wr_dir, last_dir);
    case (state)
      IDLE: begin
        stall = rd_req | wr_req;
        if (rd_req)      state_nxt = RD_WAIT;
        else if (wr_req) state_nxt = WR_WAIT;
      end
      RD_WAIT: begin
        stall   = 1'b1;
        arb_req = rd_mask & in_valid;
        // Once any selected source is valid only the winner sees ready, so
        // losing ANY sources keep their word. Ready is withheld during halt
        // so no word is consumed by an aborted read.
        if (!halt) in_ready = (|arb_req) ? arb_grant : rd_mask;
        rd_step = (|arb_grant) || (rd_mask == '0);
        if (rd_step) state_nxt = wr_op ? WR_WAIT : DONE;
      end
      WR_WAIT: begin
        stall     = 1'b1;
        out_valid = wr_mask;
        arb_req   = wr_mask & out_ready;
        wr_step   = (|arb_grant) || (wr_mask == '0);
        if (wr_step) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (halt) state_nxt = IDLE;
  end

  // Word presented by the granted read source, zero when none
  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (arb_grant[i[1:0]]) rd_val = in_data[i[1:0]];
    end
  end

  // Write data is only visible on ports currently offering it
  always_comb begin
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      out_data[i[1:0]] = out_valid[i[1:0]] ? wr_val : '0;
    end
  end

  // Operation flags, read/write data, LAST tracking and done strobes
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_data  <= '0;
      last_dir <= LD_NONE;
      wr_val   <= '0;
      rd_op    <= 1'b0;
      wr_op    <= 1'b0;
      rd_done  <= 1'b0;
      wr_done  <= 1'b0;
    end else begin
      // Strobes land in the DONE cycle; halt forces IDLE so never strobes
      rd_done <= (state_nxt == DONE) && rd_op;
      wr_done <= (state_nxt == DONE) && wr_op;
      if (!halt) begin
        case (state)
          IDLE: begin
            rd_op  <= rd_req;
            wr_op  <= wr_req;
            wr_val <= wr_data;
          end
          RD_WAIT: begin
            if (rd_step) begin
              rd_data <= rd_val;
              // A combined read+write forwards the word just read
              wr_val  <= rd_val;
              if (rd_dir == ANY && (|arb_grant)) last_dir <= grant_to_last(arb_grant);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_port_ctrl.sv
// Directed bench for port_ctrl: table of single operations plus
// hand-written stall-length, halt and reset sequences.
module tb_port_ctrl;
  import types_pkg::*;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         halt;
  logic         rd_req, wr_req;
  port_t        rd_dir, wr_dir;
  word_t        wr_data, rd_data;
  logic         rd_done, wr_done, stall;
  word_t        in_data  [4];
  logic [3:0]   in_valid, in_ready;
  word_t        out_data [4];
  logic [3:0]   out_valid, out_ready;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  port_ctrl dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .halt      (halt),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .rd_dir    (rd_dir),
    .wr_dir    (wr_dir),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .rd_done   (rd_done),
    .wr_done   (wr_done),
    .stall     (stall),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    string      name;
    logic       rd_req;
    logic       wr_req;
    port_t      rd_dir;
    port_t      wr_dir;
    word_t      wr_data;
    logic [3:0] in_valid;
    word_t      sl, sr, su, sd;
    logic [3:0] out_ready;
    int         exp_stall;
    word_t      exp_rd;
    logic       exp_rdd;
    logic       exp_wrd;
    logic [3:0] exp_rdy_seen;
    logic [3:0] exp_acc;
    logic [3:0] exp_ov_seen;
    word_t      exp_out;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    rd_dir    = NIL;
    wr_dir    = NIL;
    wr_data   = '0;
    in_valid  = '0;
    out_ready = '0;
    halt      = 1'b0;
    for (int i = 0; i < 4; i++) in_data[i] = '0;
  endtask

  // Apply one vector, follow it to the DONE cycle and compare
  task automatic run_vec(input vec_t v);
    int         st;
    logic [3:0] rs, acc, ov;
    bit         done;
    st = 0; rs = '0; acc = '0; ov = '0; done = 0;
    @(posedge CLK); #1;
    rd_req    = v.rd_req;
    wr_req    = v.wr_req;
    rd_dir    = v.rd_dir;
    wr_dir    = v.wr_dir;
    wr_data   = v.wr_data;
    in_valid  = v.in_valid;
    out_ready = v.out_ready;
    in_data[IDX_LEFT]  = v.sl;
    in_data[IDX_RIGHT] = v.sr;
    in_data[IDX_UP]    = v.su;
    in_data[IDX_DOWN]  = v.sd;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CLK);
      rs  |= in_ready;
      acc |= in_valid & in_ready;
      ov  |= out_valid;
      for (int i = 0; i < 4; i++)
        if (out_valid[i]) chk({v.name, ".out_data"}, 32'(out_data[i]), 32'(v.exp_out));
      if (stall) st++;
      else begin
        done = 1;
        chk({v.name, ".rd_done"}, 32'(rd_done), 32'(v.exp_rdd));
        chk({v.name, ".wr_done"}, 32'(wr_done), 32'(v.exp_wrd));
        if (v.rd_req) chk({v.name, ".rd_data"}, 32'(rd_data), 32'(v.exp_rd));
      end
    end
    if (!done) chk({v.name, ".timeout"}, 0, 1);
    chk({v.name, ".stall_cycles"}, st, v.exp_stall);
    chk({v.name, ".in_ready_seen"}, 32'(rs), 32'(v.exp_rdy_seen));
    chk({v.name, ".in_accepted"}, 32'(acc), 32'(v.exp_acc));
    chk({v.name, ".out_valid_seen"}, 32'(ov), 32'(v.exp_ov_seen));
    @(posedge CLK); #1;
    idle_inputs();
    @(negedge CLK);
    chk({v.name, ".rd_done_pulse"}, 32'(rd_done), 0);
    chk({v.name, ".wr_done_pulse"}, 32'(wr_done), 0);
    chk({v.name, ".stall_after"}, 32'(stall), 0);
  endtask

  function automatic vec_t mk(input string name, input logic rq, input logic wq,
                              input port_t rdir, input port_t wdir, input word_t wd,
                              input logic [3:0] iv, input word_t sl, input word_t sr,
                              input word_t su, input word_t sd, input logic [3:0] ordy,
                              input int est, input word_t erd, input logic erdd, input logic ewrd,
                              input logic [3:0] ers, input logic [3:0] eacc,
                              input logic [3:0] eov, input word_t eout);
    vec_t v;
    v.name = name; v.rd_req = rq; v.wr_req = wq; v.rd_dir = rdir; v.wr_dir = wdir;
    v.wr_data = wd; v.in_valid = iv; v.sl = sl; v.sr = sr; v.su = su; v.sd = sd;
    v.out_ready = ordy; v.exp_stall = est; v.exp_rd = erd; v.exp_rdd = erdd;
    v.exp_wrd = ewrd; v.exp_rdy_seen = ers; v.exp_acc = eacc; v.exp_ov_seen = eov;
    v.exp_out = eout;
    return v;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int         low;
    int         st;
    bit         early;
    bit         done;

    // Port index order in masks: bit0 LEFT, bit1 RIGHT, bit2 UP, bit3 DOWN
    vecs[0]  = mk("last_after_rst", 1, 0, LAST, NIL, 0, 4'b1111, 11, 12, 13, 14, 4'b0000,
                  2, 0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    vecs[1]  = mk("nil_write", 0, 1, NIL, NIL, 77, 4'b0000, 0, 0, 0, 0, 4'b1111,
                  2, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0);
    vecs[2]  = mk("rd_up", 1, 0, UP, NIL, 0, 4'b0100, 0, 0, 5, 0, 4'b0000,
                  2, 5, 1, 0, 4'b0100, 4'b0100, 4'b0000, 0);
    vecs[3]  = mk("rd_any_tie", 1, 0, ANY, NIL, 0, 4'b1001, 3, 0, 0, 9, 4'b0000,
                  2, 3, 1, 0, 4'b0001, 4'b0001, 4'b0000, 0);
    vecs[4]  = mk("rd_last_left", 1, 0, LAST, NIL, 0, 4'b1111, -20, 21, 22, 23, 4'b0000,
                  2, -20, 1, 0, 4'b0001, 4'b0001, 4'b0000, 0);
    vecs[5]  = mk("rd_wr_fwd", 1, 1, LEFT, DOWN, 5, 4'b0001, 42, 0, 0, 0, 4'b1000,
                  3, 42, 1, 1, 4'b0001, 4'b0001, 4'b1000, 42);
    vecs[6]  = mk("wr_any_tie", 0, 1, NIL, ANY, 100, 4'b0000, 0, 0, 0, 0, 4'b1010,
                  2, 0, 0, 1, 4'b0000, 4'b0000, 4'b1111, 100);
    vecs[7]  = mk("rd_any_down", 1, 0, ANY, NIL, 0, 4'b1000, 0, 0, 0, -1024, 4'b0000,
                  2, -1024, 1, 0, 4'b1000, 4'b1000, 4'b0000, 0);
    vecs[8]  = mk("wr_last_down", 0, 1, NIL, LAST, 1023, 4'b0000, 0, 0, 0, 0, 4'b1000,
                  2, 0, 0, 1, 4'b0000, 4'b0000, 4'b1000, 1023);
    vecs[9]  = mk("rd_nil", 1, 0, NIL, NIL, 0, 4'b1111, 1, 2, 3, 4, 4'b0000,
                  2, 0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    vecs[10] = mk("rd_nil_wr_right", 1, 1, NIL, RIGHT, 55, 4'b0000, 0, 0, 0, 0, 4'b0010,
                  3, 0, 1, 1, 4'b0000, 4'b0000, 4'b0010, 0);
    vecs[11] = mk("rd_right_max", 1, 0, RIGHT, NIL, 0, 4'b0010, 0, 1023, 0, 0, 4'b0000,
                  2, 1023, 1, 0, 4'b0010, 4'b0010, 4'b0000, 0);

    idle_inputs();
    nRST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst.rd_data", 32'(rd_data), 0);
    chk("rst.stall", 32'(stall), 0);
    chk("rst.rd_done", 32'(rd_done), 0);
    chk("rst.wr_done", 32'(wr_done), 0);
    chk("rst.in_ready", 32'(in_ready), 0);
    chk("rst.out_valid", 32'(out_valid), 0);
    for (int i = 0; i < 4; i++) chk("rst.out_data", 32'(out_data[i]), 0);
    nRST = 1'b1;

    foreach (vecs[k]) run_vec(vecs[k]);

    // Write RIGHT -7 with out_ready low for 10 WR_WAIT cycles
    st = 0; low = 0; early = 0; done = 0;
    @(posedge CLK); #1;
    wr_req = 1'b1; wr_dir = RIGHT; wr_data = -7; out_ready = '0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge CLK);
      if (out_valid != '0) begin
        chk("slow_wr.out_valid", 32'(out_valid), 32'(4'b0010));
        chk("slow_wr.out_data", 32'(out_data[IDX_RIGHT]), -7);
        if (!out_ready[IDX_RIGHT]) low++;
      end
      if (wr_done && !out_ready[IDX_RIGHT]) early = 1;
      if (stall) st++;
      else begin
        done = 1;
        chk("slow_wr.wr_done", 32'(wr_done), 1);
      end
      if (low == 10 && !out_ready[IDX_RIGHT]) begin
        @(posedge CLK); #1;
        out_ready[IDX_RIGHT] = 1'b1;
      end
    end
    if (!done) chk("slow_wr.timeout", 0, 1);
    chk("slow_wr.stall_cycles", st, 12);
    chk("slow_wr.early_done", 32'(early), 0);
    @(posedge CLK); #1;
    idle_inputs();

    // halt during WR_WAIT
    @(posedge CLK); #1;
    wr_req = 1'b1; wr_dir = UP; wr_data = 200; out_ready = '0;
    repeat (3) @(negedge CLK);
    chk("halt_wr.out_valid_before", 32'(out_valid), 32'(4'b0100));
    @(posedge CLK); #1;
    halt = 1'b1; wr_req = 1'b0;
    @(posedge CLK); #1;
    halt = 1'b0;
    @(negedge CLK);
    chk("halt_wr.out_valid_after", 32'(out_valid), 0);
    chk("halt_wr.stall_after", 32'(stall), 0);
    chk("halt_wr.wr_done", 32'(wr_done), 0);
    repeat (3) begin
      @(negedge CLK);
      chk("halt_wr.wr_done_later", 32'(wr_done), 0);
    end
    run_vec(vecs[2]);
    run_vec(vecs[11]);

    // nRST low during WR_WAIT (rd_data is 1023 beforehand)
    @(posedge CLK); #1;
    wr_req = 1'b1; wr_dir = LEFT; wr_data = 300; out_ready = '0;
    repeat (2) @(negedge CLK);
    chk("rst_wr.out_valid_before", 32'(out_valid), 32'(4'b0001));
    #2;
    nRST = 1'b0; wr_req = 1'b0;
    #1;
    chk("rst_wr.out_valid", 32'(out_valid), 0);
    chk("rst_wr.out_data", 32'(out_data[IDX_LEFT]), 0);
    chk("rst_wr.rd_data", 32'(rd_data), 0);
    chk("rst_wr.stall", 32'(stall), 0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      chk("rst_wr.wr_done", 32'(wr_done), 0);
      chk("rst_wr.out_valid_later", 32'(out_valid), 0);
    end
    // last_dir was DOWN before reset; LAST must now address nothing
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
